// File: rtl/seg7_display_driver.sv
// seg7_display_driver: frame-coherent multiplexed active-low hex display driver with dead-time and leading-zero blanking
module seg7_display_driver #(
  parameter int WORD_W      = 8,
  parameter int REFRESH_DIV = 1000,
  parameter int DEAD        = 2,
  parameter int DIGITS      = WORD_W / 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] display,
  input  logic              blank_lz,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              frame
);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     dig_q, dig_d;
  logic [WORD_W-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0] an_q, an_d, blank;
  logic [6:0]        seg_q, seg_d;
  logic              frame_q, frame_d, tick, off, acc;
  logic [3:0]        nib;
  always_comb begin
    tick     = cnt_q == CW'(REFRESH_DIV - 1);
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    dig_d    = tick ? (dig_q == DW'(DIGITS - 1) ? '0 : dig_q + 1'b1) : dig_q;
    frame_d  = tick && dig_q == DW'(DIGITS - 1);
    shadow_d = frame_d ? display : shadow_q;
    acc      = 1'b1;
    blank    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc      = acc & (shadow_q[4*i +: 4] == 4'd0);
      blank[i] = blank_lz & acc & (i != 0);
    end
    nib   = shadow_q[{dig_q, 2'b00} +: 4];
    off   = cnt_q < CW'(DEAD) || blank[dig_q];
    an_d  = off ? '1 : ~(DIGITS'(1) << dig_q);
    seg_d = off ? 7'h7F : HEX[nib];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      dig_q    <= '0;
      shadow_q <= '0;
      an_q     <= '1;
      seg_q    <= 7'h7F;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      frame_q  <= frame_d;
    end
  end
  assign an    = an_q;
  assign seg   = seg_q;
  assign frame = frame_q;
endmodule

// File: tb/tb_seg7_display_driver.sv
// tb_seg7_display_driver: scoreboard bench comparing the driver against a cycle model for REFRESH_DIV=4, DEAD=1, WORD_W=8
module tb_seg7_display_driver;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] display = 8'h00;
  logic       blank_lz = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame;
  int n_checks = 0;
  int n_errors = 0;
  int m_cnt = 0;
  int m_dig = 0;
  logic [7:0] m_sh = 8'h00;
  typedef struct packed {
    logic [1:0] an;
    logic [6:0] seg;
    logic       frame;
  } exp_t;
  exp_t sbq[$];
  seg7_display_driver #(.WORD_W(8), .REFRESH_DIV(4), .DEAD(1)) dut (
    .clock(clock), .reset(reset), .display(display), .blank_lz(blank_lz),
    .seg(seg), .an(an), .frame(frame)
  );
  always #5 clock = ~clock;
  function automatic logic [6:0] hex_m(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cycle();
    exp_t e, got;
    logic [3:0] nib;
    logic blank, off;
    nib   = (m_dig == 1) ? m_sh[7:4] : m_sh[3:0];
    blank = blank_lz && m_dig == 1 && m_sh[7:4] == 4'h0;
    off   = m_cnt < 1 || blank;
    if (reset) begin
      e.an = 2'b11; e.seg = 7'h7F; e.frame = 1'b0;
    end else begin
      e.an    = off ? 2'b11 : (m_dig == 1 ? 2'b01 : 2'b10);
      e.seg   = off ? 7'h7F : hex_m(nib);
      e.frame = m_cnt == 3 && m_dig == 1;
    end
    sbq.push_back(e);
    @(posedge clock);
    if (reset) begin
      m_cnt = 0; m_dig = 0; m_sh = 8'h00;
    end else begin
      if (m_cnt == 3 && m_dig == 1) m_sh = display;
      if (m_cnt == 3) begin
        m_cnt = 0; m_dig = (m_dig + 1) % 2;
      end else m_cnt++;
    end
    #1;
    got = sbq.pop_front();
    chk("sb_an", 32'(an), 32'(got.an));
    chk("sb_seg", 32'(seg), 32'(got.seg));
    chk("sb_frame", 32'(frame), 32'(got.frame));
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask
  initial begin
    logic [1:0] t_an [8];
    logic [6:0] t_seg [8];
    int n;
    logic an1_high;
    t_an  = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01};
    t_seg = '{7'h7F, 7'h08, 7'h08, 7'h08, 7'h7F, 7'h30, 7'h30, 7'h30};
    run(3);
    chk("reset_an", 32'(an), 32'h3);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_frame", 32'(frame), 32'h0);
    reset = 1'b0;
    display = 8'h3A;
    n = 0;
    do begin
      cycle();
      n++;
    end while (frame !== 1'b1 && n < 20);
    chk("first_frame_cycle", 32'(n), 32'd8);
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("frame3A_an", 32'(an), 32'(t_an[i]));
      chk("frame3A_seg", 32'(seg), 32'(t_seg[i]));
    end
    chk("frame3A_pulse", 32'(frame), 32'h1);
    display = 8'h12;
    run(8);
    run(3);
    display = 8'h34;
    run(5);
    chk("mid_change_frame", 32'(frame), 32'h1);
    run(16);
    display = 8'h05;
    blank_lz = 1'b1;
    run(8);
    an1_high = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (an[1] !== 1'b1) an1_high = 1'b0;
    end
    chk("lz_an1_high", 32'(an1_high), 32'h1);
    blank_lz = 1'b0;
    run(8);
    display = 8'h00;
    blank_lz = 1'b1;
    run(16);
    blank_lz = 1'b0;
    display = 8'h77;
    run(16);
    n = 0;
    while (!(m_dig == 1 && m_cnt == 2) && n < 20) begin
      cycle();
      n++;
    end
    chk("reach_mid_scan", 32'(m_dig == 1 && m_cnt == 2), 32'h1);
    reset = 1'b1;
    cycle();
    chk("midreset_an", 32'(an), 32'h3);
    chk("midreset_seg", 32'(seg), 32'h7F);
    reset = 1'b0;
    display = 8'h00;
    run(24);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
